// File: rtl/dft_peak_find.sv
// Per-frame peak search over squared-magnitude DFT bins: max, argmax, count above threshold.
// Latency: result valid 1 cycle after the last bin of a frame is accepted.
// Backpressure: in_ready drops while a result is held; it returns the cycle after res_valid&res_ready.
module dft_peak_find #(
  parameter int DATA_W = 32,
  parameter int BINS_N = 64,
  parameter int IDX_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data,
  input  logic              valid,
  input  logic              sof,
  input  logic [DATA_W-1:0] thr,
  output logic              in_ready,
  output logic [DATA_W-1:0] peak_val,
  output logic [IDX_W-1:0]  peak_idx,
  output logic [IDX_W:0]    above_cnt,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              frame_err
);

  localparam logic [IDX_W-1:0] LAST_BIN = IDX_W'(BINS_N - 1);

  typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;

  state_t state, state_nxt;

  // Running values for the frame in progress; never driven onto the outputs directly.
  logic [IDX_W-1:0]  bin_cnt;
  logic [DATA_W-1:0] cur_max;
  logic [IDX_W-1:0]  cur_idx;
  logic [IDX_W:0]    cur_cnt;

  logic              accept;
  logic              restart;
  logic              last_bin;
  logic              above;
  logic              new_peak;
  logic [DATA_W-1:0] max_nxt;
  logic [IDX_W-1:0]  idx_nxt;
  logic [IDX_W:0]    cnt_nxt;

  // Acceptance and candidate running values; acceptance is decoded from state so res_ready never reaches in_ready.
  always_comb begin
    accept   = valid && (state != HOLD);
    restart  = accept && ((state == IDLE) || sof);
    last_bin = accept && !restart && (bin_cnt == LAST_BIN);
    above    = data > thr;
    // Strict compare keeps the earliest bin on ties.
    new_peak = data > cur_max;
    max_nxt  = new_peak ? data : cur_max;
    idx_nxt  = new_peak ? bin_cnt : cur_idx;
    cnt_nxt  = cur_cnt + {{IDX_W{1'b0}}, above};
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state and state-decoded handshake outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    res_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (accept) state_nxt = SCAN;
      end
      SCAN: begin
        in_ready = 1'b1;
        if (last_bin) state_nxt = HOLD;
      end
      HOLD: begin
        res_valid = 1'b1;
        if (res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Scan accumulation, result capture at frame completion, and restart error pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bin_cnt   <= '0;
      cur_max   <= '0;
      cur_idx   <= '0;
      cur_cnt   <= '0;
      peak_val  <= '0;
      peak_idx  <= '0;
      above_cnt <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= accept && (state == SCAN) && sof;
      if (restart) begin
        cur_max <= data;
        cur_idx <= '0;
        cur_cnt <= {{IDX_W{1'b0}}, above};
        bin_cnt <= IDX_W'(1);
      end else if (accept) begin
        cur_max <= max_nxt;
        cur_idx <= idx_nxt;
        cur_cnt <= cnt_nxt;
        // Wraps to zero naturally when the last bin is taken.
        bin_cnt <= bin_cnt + IDX_W'(1);
        if (last_bin) begin
          peak_val  <= max_nxt;
          peak_idx  <= idx_nxt;
          above_cnt <= cnt_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_dft_peak_find.sv
// Bench for dft_peak_find: directed frames plus randomized gapped frames against a max/argmax/count model.
// Latency: expects the result one cycle after the last accepted bin.
// Backpressure: exercises res_ready stalls with ignored valid pulses in the hold state.
module tb_dft_peak_find;

  localparam int DATA_W = 32;
  localparam int BINS_N = 64;
  localparam int IDX_W  = 6;

  logic              tb_clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              sof;
  logic [DATA_W-1:0] thr;
  logic              in_ready;
  logic [DATA_W-1:0] peak_val;
  logic [IDX_W-1:0]  peak_idx;
  logic [IDX_W:0]    above_cnt;
  logic              res_valid;
  logic              res_ready;
  logic              frame_err;

  always #5 tb_clk = ~tb_clk;

  dft_peak_find #(.DATA_W(DATA_W), .BINS_N(BINS_N), .IDX_W(IDX_W)) dut (
    .clk(tb_clk), .rst(rst), .data(data), .valid(valid), .sof(sof), .thr(thr),
    .in_ready(in_ready), .peak_val(peak_val), .peak_idx(peak_idx), .above_cnt(above_cnt),
    .res_valid(res_valid), .res_ready(res_ready), .frame_err(frame_err)
  );

  int vec_cnt = 0;
  int err_cnt = 0;
  int stall   = 0;

  // Samples of the frame currently being collected (data and its threshold).
  logic [DATA_W-1:0] qd[$];
  logic [DATA_W-1:0] qt[$];

  // Most recently reported result; outputs must equal these outside of completion.
  logic [DATA_W-1:0] exp_val;
  logic [IDX_W-1:0]  exp_idx;
  logic [IDX_W:0]    exp_cnt;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_val"}, 64'(peak_val), 64'(exp_val));
    chk({tag, "_idx"}, 64'(peak_idx), 64'(exp_idx));
    chk({tag, "_cnt"}, 64'(above_cnt), 64'(exp_cnt));
  endtask

  // Reference: max over the frame, first index holding it, and number of bins above their threshold.
  task automatic model_frame();
    logic [DATA_W-1:0] m;
    int first;
    int c;
    m = 0;
    foreach (qd[i]) if (qd[i] > m) m = qd[i];
    first = -1;
    foreach (qd[i]) if (first < 0 && qd[i] == m) first = i;
    c = 0;
    foreach (qd[i]) if (qd[i] > qt[i]) c++;
    exp_val = m;
    exp_idx = IDX_W'(first);
    exp_cnt = (IDX_W+1)'(c);
  endtask

  // Idle cycles with valid low; nothing may change.
  task automatic gap(input int n);
    valid = 1'b0;
    repeat (n) begin
      @(posedge tb_clk); #1;
      chk("gap_frame_err", 64'(frame_err), 64'd0);
      chk("gap_res_valid", 64'(res_valid), 64'd0);
      check_outputs("gap");
    end
  endtask

  // Offer one sample; the DUT is expected to be ready. Handles result checking and release on completion.
  task automatic push(input logic [DATA_W-1:0] d, input logic s, input logic [DATA_W-1:0] t);
    logic exp_err;
    chk("in_ready_pre", 64'(in_ready), 64'd1);
    exp_err = s && (qd.size() > 0);
    if (s) begin
      qd.delete();
      qt.delete();
    end
    qd.push_back(d);
    qt.push_back(t);
    data = d; sof = s; thr = t; valid = 1'b1;
    @(posedge tb_clk); #1;
    valid = 1'b0; sof = 1'b0;
    chk("frame_err", 64'(frame_err), 64'(exp_err));
    if (qd.size() == BINS_N) begin
      model_frame();
      chk("done_res_valid", 64'(res_valid), 64'd1);
      chk("done_in_ready", 64'(in_ready), 64'd0);
      check_outputs("done");
      for (int i = 0; i < stall; i++) begin
        valid = 1'($urandom % 2);
        data  = $urandom;
        sof   = 1'($urandom % 2);
        @(posedge tb_clk); #1;
        chk("stall_res_valid", 64'(res_valid), 64'd1);
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        check_outputs("stall");
      end
      valid = 1'b0; sof = 1'b0; res_ready = 1'b1;
      @(posedge tb_clk); #1;
      res_ready = 1'b0;
      chk("rel_res_valid", 64'(res_valid), 64'd0);
      chk("rel_in_ready", 64'(in_ready), 64'd1);
      check_outputs("rel");
      qd.delete();
      qt.delete();
    end else begin
      chk("scan_res_valid", 64'(res_valid), 64'd0);
      check_outputs("scan");
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    chk({tag, "_res_valid"}, 64'(res_valid), 64'd0);
    chk({tag, "_frame_err"}, 64'(frame_err), 64'd0);
    chk({tag, "_val"}, 64'(peak_val), 64'd0);
    chk({tag, "_idx"}, 64'(peak_idx), 64'd0);
    chk({tag, "_cnt"}, 64'(above_cnt), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; data = '0; valid = 1'b0; sof = 1'b0; thr = '0; res_ready = 1'b0;
    exp_val = '0; exp_idx = '0; exp_cnt = '0;
    repeat (2) @(posedge tb_clk);
    #1;
    check_reset_values("reset");
    rst = 1'b1;
    @(posedge tb_clk); #1;

    // Ramp with a spike at bin 37.
    for (int b = 0; b < BINS_N; b++)
      push((b == 37) ? 32'd5000 : 32'(b * 10), (b == 0), 32'd300);
    chk("ramp_val", 64'(peak_val), 64'd5000);
    chk("ramp_idx", 64'(peak_idx), 64'd37);
    chk("ramp_cnt", 64'(above_cnt), 64'd33);

    // Flat frame equal to threshold, then zero threshold.
    for (int b = 0; b < BINS_N; b++) push(32'h100, 1'b0, 32'h100);
    chk("flat_idx", 64'(peak_idx), 64'd0);
    chk("flat_val", 64'(peak_val), 64'h100);
    chk("flat_cnt", 64'(above_cnt), 64'd0);
    for (int b = 0; b < BINS_N; b++) push(32'h100, 1'b0, 32'd0);
    chk("flat0_cnt", 64'(above_cnt), 64'd64);

    // Restart on the 20th sample; frame_err must last exactly one cycle.
    for (int b = 0; b < 19; b++) push(32'd7000 + 32'(b), 1'b0, 32'd50);
    push(32'd3, 1'b1, 32'd50);
    gap(1);
    for (int b = 1; b < BINS_N; b++) push(32'(($urandom % 4000)), 1'b0, 32'd1000);
    chk("restart_val_lt_7000", 64'(peak_val < 32'd7000), 64'd1);

    // Held result with ignored valid pulses.
    stall = 10;
    for (int b = 0; b < BINS_N; b++) push($urandom, 1'b0, $urandom);
    stall = 0;

    // Random frames with 1-of-2 valid duty; small data range to create ties.
    for (int f = 0; f < 16; f++) begin
      for (int b = 0; b < BINS_N; b++) begin
        push((f % 2 == 0) ? 32'($urandom_range(0, 15)) : $urandom,
             ((b > 0) && ($urandom_range(0, 199) == 0)),
             (f % 2 == 0) ? 32'($urandom_range(0, 15)) : $urandom);
        gap(1);
      end
      // A random restart leaves a partial frame open; finish it.
      while (qd.size() != 0) begin
        push(32'($urandom_range(0, 15)), 1'b0, 32'd8);
        gap(int'($urandom_range(0, 1)));
      end
    end

    // Reset during bin 40, then a full frame starting without sof.
    for (int b = 0; b < 40; b++) push(32'(b), 1'b0, 32'd10);
    #1 rst = 1'b0;
    #1;
    exp_val = '0; exp_idx = '0; exp_cnt = '0;
    qd.delete(); qt.delete();
    check_reset_values("midrst");
    #2 rst = 1'b1;
    @(posedge tb_clk); #1;
    for (int b = 0; b < BINS_N; b++) push(32'(BINS_N - b), 1'b0, 32'd60);
    chk("postrst_val", 64'(peak_val), 64'd64);
    chk("postrst_idx", 64'(peak_idx), 64'd0);
    chk("postrst_cnt", 64'(above_cnt), 64'd4);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/dft_peak_find.md
DFT_PEAK_FIND -- requirements
Module: dft_peak_find

Interface
REQ-001 Parameter DATA_W, default 32, width of the unsigned power samples from the squared-magnitude stage.
REQ-002 Parameter BINS_N, default 64, number of bins per frame (power of two, at least 4).
REQ-003 Parameter IDX_W, default 6, bin index width, equal to log2(BINS_N).
REQ-004 Port clk, input, 1 bit, system clock; all state changes on the rising edge.
REQ-005 Port rst, input, 1 bit, reset; asynchronous, active-low (0 = reset).
REQ-006 Port data, input, DATA_W bits, unsigned power sample for the current bin.
REQ-007 Port valid, input, 1 bit, data qualifier; a sample is accepted on a rising edge where valid=1 and in_ready=1.
REQ-008 Port sof, input, 1 bit, start of frame; sampled only with an accepted sample.
REQ-009 Port thr, input, DATA_W bits, unsigned detection threshold; sampled on every accepted sample.
REQ-010 Port in_ready, output, 1 bit, block can accept a sample.
REQ-011 Port peak_val, output, DATA_W bits, maximum power in the completed frame.
REQ-012 Port peak_idx, output, IDX_W bits, bin index of peak_val.
REQ-013 Port above_cnt, output, IDX_W+1 bits, count of bins in the frame with data > thr.
REQ-014 Port res_valid, output, 1 bit, result outputs are valid and held stable.
REQ-015 Port res_ready, input, 1 bit, downstream accepts the result when res_valid=1 and res_ready=1.
REQ-016 Port frame_err, output, 1 bit, one-cycle pulse when a partial frame is discarded.

Function
REQ-017 States: IDLE, SCAN, HOLD; in_ready=1 in IDLE and SCAN, 0 in HOLD (decoded from state only, no combinational path from res_ready).
REQ-018 IDLE: an accepted sample (sof ignored) is bin 0: max<=data, idx<=0, cnt<=(data>thr), bin counter<=1, next state SCAN.
REQ-019 SCAN: an accepted sample with sof=0 is bin k = bin counter; if data > max then max<=data and idx<=k (strict compare, lowest index wins ties); cnt increments when data > thr.
REQ-020 SCAN: an accepted sample with sof=1 restarts as bin 0 per REQ-018, stays in SCAN, and asserts frame_err for exactly the next cycle.
REQ-021 Frame completes on acceptance of bin BINS_N-1: the next cycle has res_valid=1 with peak_val, peak_idx and above_cnt including that bin; state HOLD. Latency is 1 cycle from the last accepted sample.
REQ-022 HOLD: outputs are frozen and valid is ignored; on res_valid=1 and res_ready=1, the next cycle has res_valid=0, state IDLE, in_ready=1.
REQ-023 Cycles with valid=0 in SCAN leave all state unchanged; gaps of any length are allowed.
REQ-024 The bin counter is IDX_W bits and wraps to 0 at frame completion; above_cnt reaches BINS_N without overflow.
REQ-025 Result registers are updated only at frame completion; partial-scan values are never visible on peak_val, peak_idx or above_cnt.

Reset
REQ-026 rst=0 forces asynchronously: state IDLE, in_ready=1, res_valid=0, frame_err=0, peak_val=0, peak_idx=0, above_cnt=0, bin counter=0, internal max and count=0.
REQ-027 Reset asserted mid-SCAN or in HOLD discards the frame with no frame_err pulse; the first sample accepted after release is bin 0.

Verification
REQ-028 64 samples, data=bin*10 except bin 37=5000, thr=300, res_ready=1 -> peak_val=5000, peak_idx=37, above_cnt=33 (bins 31..63), res_valid one cycle after bin 63.
REQ-029 All 64 samples = 0x100 with thr=0x100 -> peak_idx=0, peak_val=0x100, above_cnt=0; then thr=0 in a second frame -> above_cnt=64.
REQ-030 sof=1 on the 20th sample of a frame -> frame_err pulses once and the result reflects only the 64 samples starting at that one.
REQ-031 res_ready held 0 for 10 cycles after completion -> res_valid and outputs stay stable, in_ready=0, valid pulses are ignored; res_ready=1 -> IDLE on the next cycle.
REQ-032 Random gaps on valid (1-of-2 duty, as driven by the upstream squared-magnitude stage) with random data -> results match a reference max/argmax/count model for 16 frames.
REQ-033 rst=0 pulsed during bin 40 -> outputs at reset values immediately, and the next full 64-sample frame is reported correctly.
